mips_id_stage: RTL

Instruction-decode stage of the five-stage MIPS pipeline, directly downstream of the fetch stage's IF/ID pipeline register. It consumes the latched PC+4 and instruction and reads the 32×32 register file, which it owns. It generates the main control bits, detects load-use hazards, and drives a stall back to fetch. Its own ID/EX pipeline register feeds the execute stage.

---
 rtl/mips_id_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mips_id_stage.sv
// MIPS instruction-decode stage: register file, main control decode,
// load-use hazard detection and the ID/EX pipeline register.
module mips_id_stage (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IF_ID_NEXT_INS_ADR,
  input  logic [31:0] IF_ID_CUR_INS,
  input  logic        WB_REG_WRITE,
  input  logic [4:0]  WB_WRITE_REG,
  input  logic [31:0] WB_WRITE_DATA,
  input  logic        ID_EX_FLUSH,
  output logic        STALL,
  output logic [31:0] ID_EX_NEXT_INS_ADR,
  output logic [31:0] ID_EX_READ_DATA1,
  output logic [31:0] ID_EX_READ_DATA2,
  output logic [31:0] ID_EX_SIGN_EXT_IMM,
  output logic [4:0]  ID_EX_RS,
  output logic [4:0]  ID_EX_RT,
  output logic [4:0]  ID_EX_RD,
  output logic [1:0]  ID_EX_WB,
  output logic [2:0]  ID_EX_M,
  output logic [3:0]  ID_EX_EX
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  logic [31:0]        rf [32];
  logic               wr_en;
  logic [5:0]         opcode_p0;
  logic [4:0]         rs_p0, rt_p0, rd_p0;
  logic [31:0]        rd1_p0, rd2_p0;
  logic signed [31:0] imm_p0;
  logic [1:0]         wb_p0;
  logic [2:0]         m_p0;
  logic [3:0]         ex_p0;
  logic               bubble_p0;

  function automatic logic signed [31:0] sign_ext(input logic [15:0] v);
    return $signed({{16{v[15]}}, v});
  endfunction

  assign wr_en = WB_REG_WRITE && (WB_WRITE_REG != 5'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[WB_WRITE_REG] <= WB_WRITE_DATA;
    end
  end

  // ---- p0: field extraction, register read with write-through, decode
  assign opcode_p0 = IF_ID_CUR_INS[31:26];
  assign rs_p0     = IF_ID_CUR_INS[25:21];
  assign rt_p0     = IF_ID_CUR_INS[20:16];
  assign rd_p0     = IF_ID_CUR_INS[15:11];
  assign imm_p0    = sign_ext(IF_ID_CUR_INS[15:0]);

  always_comb begin
    rd1_p0 = rf[rs_p0];
    if (rs_p0 == 5'd0)                          rd1_p0 = '0;
    else if (wr_en && (WB_WRITE_REG == rs_p0))  rd1_p0 = WB_WRITE_DATA;
  end

  always_comb begin
    rd2_p0 = rf[rt_p0];
    if (rt_p0 == 5'd0)                          rd2_p0 = '0;
    else if (wr_en && (WB_WRITE_REG == rt_p0))  rd2_p0 = WB_WRITE_DATA;
  end

  // WB={RegWrite,MemtoReg}  M={Branch,MemRead,MemWrite}  EX={RegDst,ALUOp,ALUSrc}
  always_comb begin
    wb_p0 = 2'b00;
    m_p0  = 3'b000;
    ex_p0 = 4'b0000;
    case (opcode_p0)
      OP_RTYPE: begin wb_p0 = 2'b10; m_p0 = 3'b000; ex_p0 = 4'b1100; end
      OP_LW:    begin wb_p0 = 2'b11; m_p0 = 3'b010; ex_p0 = 4'b0001; end
      OP_SW:    begin wb_p0 = 2'b00; m_p0 = 3'b001; ex_p0 = 4'b0001; end
      OP_BEQ:   begin wb_p0 = 2'b00; m_p0 = 3'b100; ex_p0 = 4'b0010; end
      OP_ADDI:  begin wb_p0 = 2'b10; m_p0 = 3'b000; ex_p0 = 4'b0001; end
      default:  begin wb_p0 = 2'b00; m_p0 = 3'b000; ex_p0 = 4'b0000; end
    endcase
  end

  // A load in EX whose target is read here must wait one cycle for the data.
  assign STALL = ID_EX_M[1] && (ID_EX_RT != 5'd0) &&
                 ((ID_EX_RT == rs_p0) || (ID_EX_RT == rt_p0));
  assign bubble_p0 = STALL || ID_EX_FLUSH;

  // ---- p1: ID/EX register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ID_EX_NEXT_INS_ADR <= '0;
      ID_EX_READ_DATA1   <= '0;
      ID_EX_READ_DATA2   <= '0;
      ID_EX_SIGN_EXT_IMM <= '0;
      ID_EX_RS           <= '0;
      ID_EX_RT           <= '0;
      ID_EX_RD           <= '0;
      ID_EX_WB           <= '0;
      ID_EX_M            <= '0;
      ID_EX_EX           <= '0;
    end else begin
      ID_EX_NEXT_INS_ADR <= IF_ID_NEXT_INS_ADR;
      ID_EX_READ_DATA1   <= rd1_p0;
      ID_EX_READ_DATA2   <= rd2_p0;
      ID_EX_SIGN_EXT_IMM <= imm_p0;
      ID_EX_RS           <= rs_p0;
      ID_EX_RT           <= rt_p0;
      ID_EX_RD           <= rd_p0;
      ID_EX_WB           <= bubble_p0 ? 2'b00   : wb_p0;
      ID_EX_M            <= bubble_p0 ? 3'b000  : m_p0;
      ID_EX_EX           <= bubble_p0 ? 4'b0000 : ex_p0;
    end
  end

endmodule
